mouse_sprite_ctrl: RTL and testbench

Controller and sequencer for the dual-port mouse-pointer sprite RAM (12-bit colour, 1024 words, 1-cycle registered read). Read side: turns the VGA scan position and mouse position into sprite RAM read addresses, absorbs the RAM latency, and overlays sprite pixels on the incoming video stream with a chroma key. Write side: shares the single RAM write port between host pixel writes and an internal whole-sprite fill engine. Sits between the VGA sync/pixel-generation chain and the sprite RAM instance.

---
 rtl/mouse_pkg.sv | 15 +
 rtl/mouse_wr_arb.sv | 75 +++++++
 rtl/mouse_sprite_ctrl.sv | 105 ++++++++++
 tb/tb_mouse_sprite_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared constants and types for the mouse-pointer sprite controller.
package mouse_pkg;

    localparam int SPR_BITS_DEF  = 5;
    localparam int SPR_SIDE      = 32;
    localparam int SPR_WORDS     = 1024;
    localparam logic [11:0] KEY_COLOR_DEF = 12'hF0F;

    // Ownership of the sprite RAM write port.
    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_FILL = 1'b1
    } wr_state_t;

endpackage

// File: rtl/mouse_wr_arb.sv
// Sprite RAM write-port arbiter: host pixel writes versus whole-sprite fill.
// While idle the host owns the port; a fill request takes it for exactly one
// write per sprite word, then hands it back.
module mouse_wr_arb
    import mouse_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int AW         = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_color,
    output logic                  fill_busy,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din
);

    wr_state_t             state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;

    // State, fill address counter and latched fill colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WR_IDLE;
            cnt_q   <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
        end
    end

    // Next state and write-port mux; a simultaneous fill request beats the host.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        color_d    = color_q;
        wr_ready   = 1'b0;
        fill_busy  = 1'b0;
        ram_we     = 1'b0;
        ram_addr_w = wr_addr;
        ram_din    = wr_data;
        case (state_q)
            WR_IDLE: begin
                wr_ready = !fill_start;
                ram_we   = wr_en && !fill_start;
                if (fill_start) begin
                    state_d = WR_FILL;
                    cnt_d   = '0;
                    color_d = fill_color;
                end
            end
            WR_FILL: begin
                fill_busy  = 1'b1;
                ram_we     = 1'b1;
                ram_addr_w = cnt_q;
                ram_din    = color_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

endmodule

// File: rtl/mouse_sprite_ctrl.sv
// Mouse-pointer sprite controller: frame-latched pointer position, two-stage
// read/overlay pipeline with chroma key, and the write-port arbiter.
// Build option: MOUSE_CTRL_SCALE2X_EN shows the sprite pixel-doubled (64x64).
module mouse_sprite_ctrl
    import mouse_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int SPR_BITS   = SPR_BITS_DEF,
    parameter int CORD_W     = 11,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CORD_W-1:0]       x,
    input  logic [CORD_W-1:0]       y,
    input  logic                    frame_start,
    input  logic [CORD_W-1:0]       mouse_x,
    input  logic [CORD_W-1:0]       mouse_y,
    input  logic [DATA_WIDTH-1:0]   si_rgb,
    output logic [DATA_WIDTH-1:0]   so_rgb,
    input  logic                    wr_en,
    input  logic [2*SPR_BITS-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    input  logic                    fill_start,
    input  logic [DATA_WIDTH-1:0]   fill_color,
    output logic                    fill_busy,
    output logic                    ram_we,
    output logic [2*SPR_BITS-1:0]   ram_addr_w,
    output logic [DATA_WIDTH-1:0]   ram_din,
    output logic [2*SPR_BITS-1:0]   ram_addr_r,
    input  logic [DATA_WIDTH-1:0]   ram_dout
);

`ifdef MOUSE_CTRL_SCALE2X_EN
    localparam logic [CORD_W:0] WIN = (CORD_W+1)'(2 << SPR_BITS);
`else
    localparam logic [CORD_W:0] WIN = (CORD_W+1)'(1 << SPR_BITS);
`endif

    logic [CORD_W-1:0]     pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic                  hit1_q, hit1_d;
    logic [DATA_WIDTH-1:0] rgb1_q, rgb1_d;
    logic [DATA_WIDTH-1:0] so_rgb_q, so_rgb_d;
    logic [CORD_W:0]       dx, dy;
    logic                  hit0;

    // Pointer position, stage-1 and stage-2 pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            hit1_q   <= 1'b0;
            rgb1_q   <= '0;
            so_rgb_q <= '0;
        end else begin
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            hit1_q   <= hit1_d;
            rgb1_q   <= rgb1_d;
            so_rgb_q <= so_rgb_d;
        end
    end

    // Stage 0: window test and read address. Offsets are one bit wider than the
    // coordinates so a pointer near the right/bottom edge never wraps to 0; when
    // x >= pos_x the offset is exact, so comparing it to the window size is the
    // same as comparing x against pos_x + window.
    always_comb begin
        pos_x_d = frame_start ? mouse_x : pos_x_q;
        pos_y_d = frame_start ? mouse_y : pos_y_q;
        dx      = {1'b0, x} - {1'b0, pos_x_q};
        dy      = {1'b0, y} - {1'b0, pos_y_q};
        hit0    = (x >= pos_x_q) && (dx < WIN) && (y >= pos_y_q) && (dy < WIN);
`ifdef MOUSE_CTRL_SCALE2X_EN
        ram_addr_r = {dy[SPR_BITS:1], dx[SPR_BITS:1]};
`else
        ram_addr_r = {dy[SPR_BITS-1:0], dx[SPR_BITS-1:0]};
`endif
        hit1_d   = hit0;
        rgb1_d   = si_rgb;
        so_rgb_d = (hit1_q && (ram_dout != KEY_COLOR)) ? ram_dout : rgb1_q;
    end

    assign so_rgb = so_rgb_q;

    mouse_wr_arb #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (2*SPR_BITS)
    ) u_wr_arb (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .ram_we     (ram_we),
        .ram_addr_w (ram_addr_w),
        .ram_din    (ram_din)
    );

endmodule

// File: tb/tb_mouse_sprite_ctrl.sv
// Bench for mouse_sprite_ctrl with a behavioural 1024x12 registered-read RAM.
module tb_mouse_sprite_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = '0, y = '0, mouse_x = '0, mouse_y = '0;
    logic        frame_start = 1'b0;
    logic [11:0] si_rgb = '0, so_rgb;
    logic        wr_en = 1'b0, wr_ready;
    logic [9:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        fill_start = 1'b0, fill_busy;
    logic [11:0] fill_color = '0;
    logic        ram_we;
    logic [9:0]  ram_addr_w, ram_addr_r;
    logic [11:0] ram_din, ram_dout;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [11:0] exp;
        string       name;
    } pix_t;
    pix_t sb_q[$];

    logic [11:0] mem [0:1023];
    int fill_addr_exp = 0;
    int fill_bad = 0;

    always #5 clk = ~clk;

    mouse_sprite_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .si_rgb     (si_rgb),
        .so_rgb     (so_rgb),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .ram_we     (ram_we),
        .ram_addr_w (ram_addr_w),
        .ram_din    (ram_din),
        .ram_addr_r (ram_addr_r),
        .ram_dout   (ram_dout)
    );

    // Sprite RAM model; also tracks that fill writes walk 0..1023 in order.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr_r];
        if (ram_we) begin
            mem[ram_addr_w] <= ram_din;
            if (fill_busy) begin
                if (int'(ram_addr_w) != fill_addr_exp || ram_din != fill_color)
                    fill_bad = fill_bad + 1;
                fill_addr_exp = fill_addr_exp + 1;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end else begin
            $display("[TB] ok %s = 'h%0h", nm, act);
        end
    endtask

    // Monitor: so_rgb presents one pixel per cycle, two cycles after stimulus.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                pix_t e;
                e = sb_q.pop_front();
                if (e.due < cyc) check({e.name, " (missed slot)"}, 1, 0);
                else             check(e.name, int'(so_rgb), int'(e.exp));
            end
        end
    end

    task automatic pix(input int px, input int py, input logic [11:0] bg,
                       input logic [11:0] exp, input string nm);
        pix_t e;
        @(negedge clk);
        x      = 11'(px);
        y      = 11'(py);
        si_rgb = bg;
        e.due  = cyc + 2;
        e.exp  = exp;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic frame(input int mx, input int my);
        @(negedge clk);
        mouse_x     = 11'(mx);
        mouse_y     = 11'(my);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic host_wr(input int a, input logic [11:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 10'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) check("scoreboard drain", sb_q.size(), 0);
    endtask

    initial begin
        int busy_cnt;
        int bad;
        for (int i = 0; i < 1024; i++) mem[i] = 12'h000;

        // Reset state.
        #1;
        check("reset so_rgb", int'(so_rgb), 0);
        check("reset fill_busy", int'(fill_busy), 0);
        check("reset ram_we", int'(ram_we), 0);
        check("reset wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Sprite contents via host writes.
        host_wr(0, 12'h00F);
        host_wr(1, 12'hF0F);
        host_wr(1023, 12'hABC);
        check("host write word0", int'(mem[0]), 'h00F);

        // Overlay at (100,50).
        frame(100, 50);
        pix(100, 50, 12'h123, 12'h00F, "pix(100,50) sprite");
        pix(99,  50, 12'h456, 12'h456, "pix(99,50) left edge bg");
        pix(101, 50, 12'h789, 12'h789, "pix(101,50) key colour");
        pix(131, 81, 12'h111, 12'hABC, "pix(131,81) last word");
        pix(132, 81, 12'h222, 12'h222, "pix(132,81) right edge bg");
        pix(131, 82, 12'h333, 12'h333, "pix(131,82) bottom edge bg");
        pix(100, 49, 12'h444, 12'h444, "pix(100,49) top edge bg");
        drain();

        // Mid-frame pointer move is ignored until the next frame_start.
        @(negedge clk);
        mouse_x = 11'd300;
        pix(100, 50, 12'h555, 12'h00F, "no tear old pos");
        pix(300, 50, 12'h666, 12'h666, "no tear new pos bg");
        frame(300, 50);
        pix(300, 50, 12'h777, 12'h00F, "moved new pos");
        pix(100, 50, 12'h888, 12'h888, "moved old pos bg");
        drain();

        // Fill and host write in the same cycle: fill wins, host holds.
        @(negedge clk);
        fill_start = 1'b1;
        fill_color = 12'h0F0;
        wr_en      = 1'b1;
        wr_addr    = 10'd5;
        wr_data    = 12'h777;
        #1;
        check("wr_ready low on fill_start", int'(wr_ready), 0);
        check("no host write on fill_start", int'(ram_we), 0);
        @(negedge clk);
        fill_start = 1'b0;
        busy_cnt = 0;
        bad = 0;
        while (fill_busy && busy_cnt < 2000) begin
            busy_cnt++;
            if (wr_ready) bad++;
            @(negedge clk);
        end
        check("fill_busy cycles", busy_cnt, 1024);
        check("wr_ready low during fill", bad, 0);
        check("fill write sequence errors", fill_bad, 0);
        check("host accepted after fill", int'(wr_ready && ram_we && ram_addr_w == 10'd5), 1);
        @(negedge clk);
        wr_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (i != 5 && mem[i] != 12'h0F0) bad++;
        check("fill readback bad words", bad, 0);
        check("held host write word5", int'(mem[5]), 'h777);

        // No wrap near the maximum coordinate.
        frame(2040, 2040);
        pix(5, 5, 12'h321, 12'h321, "no wrap pix(5,5)");
        pix(2040, 2040, 12'h432, 12'h0F0, "pix(2040,2040) sprite");
        pix(2047, 2047, 12'h543, 12'h0F0, "pix(2047,2047) sprite");
        pix(2039, 2040, 12'h654, 12'h654, "pix(2039,2040) bg");
        drain();

        // Reset aborts a fill with the counter at 500.
        @(negedge clk);
        fill_start    = 1'b1;
        fill_color    = 12'h111;
        fill_addr_exp = 0;
        @(negedge clk);
        fill_start = 1'b0;
        busy_cnt = 1;
        while (busy_cnt < 501 && fill_busy) begin
            @(negedge clk);
            busy_cnt++;
        end
        check("fill still busy at cnt 500", int'(fill_busy), 1);
        reset = 1'b1;
        #1;
        check("abort fill_busy", int'(fill_busy), 0);
        check("abort so_rgb", int'(so_rgb), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("after abort ram_we", int'(ram_we), 0);
        check("partial fill word499", int'(mem[499]), 'h111);
        check("partial fill word500 kept", int'(mem[500]), 'h0F0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Overall time guard.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests %0d", tests);
        $fatal(1, "timeout");
    end

endmodule
